// File: rtl/gfx_pkg.sv
// Shared graphics constants, FSM state type and ROM address layout for the
// sprite blitter and its raster counter.
package gfx_pkg;

  localparam int SCREEN_W_DEF = 320;
  localparam int SCREEN_H_DEF = 240;

  localparam int SPRITE_DIM   = 16;
  localparam int SPRITE_IDX_W = 2;

  localparam int X_W      = 9;
  localparam int Y_W      = 8;
  localparam int COLOUR_W = 3;

  localparam int ROM_COORD_W = 4;
  localparam int ROM_ADDR_W  = SPRITE_IDX_W + 2 * ROM_COORD_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_FLUSH,
    ST_DONE
  } blit_state_t;

  function automatic logic [ROM_ADDR_W-1:0] rom_addr_of(
    input logic [SPRITE_IDX_W-1:0] id,
    input logic [ROM_COORD_W-1:0]  row,
    input logic [ROM_COORD_W-1:0]  col
  );
    return {id, row, col};
  endfunction

endpackage

// File: rtl/raster_counter.sv
// 2-D wrap counter: inner runs 0..inner_lim-1, outer advances on inner wrap;
// last flags the final position of the scan.
module raster_counter #(
  parameter int IW = 9,
  parameter int OW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          en,
  input  logic [IW-1:0] inner_lim,
  input  logic [OW-1:0] outer_lim,
  output logic [IW-1:0] inner,
  output logic [OW-1:0] outer,
  output logic          last
);

  logic inner_wrap;

  assign inner_wrap = (inner == inner_lim - IW'(1));
  assign last       = inner_wrap && (outer == outer_lim - OW'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inner <= '0;
      outer <= '0;
    end else if (clr) begin
      inner <= '0;
      outer <= '0;
    end else if (en) begin
      if (inner_wrap) begin
        inner <= '0;
        outer <= last ? '0 : outer + OW'(1);
      end else begin
        inner <= inner + IW'(1);
      end
    end
  end

endmodule

// File: rtl/sprite_blitter.sv
// Sprite draw / screen fill pixel-stream engine with clipping.
// Optional colour-key transparency: define SPRITE_TRANSPARENCY_EN.
module sprite_blitter
  import gfx_pkg::*;
#(
  parameter int                    SCREEN_W           = SCREEN_W_DEF,
  parameter int                    SCREEN_H           = SCREEN_H_DEF,
  parameter logic [COLOUR_W-1:0]   TRANSPARENT_COLOUR = 3'b000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_clear,
  input  logic [X_W-1:0]          req_x,
  input  logic [Y_W-1:0]          req_y,
  input  logic [SPRITE_IDX_W-1:0] req_id,
  input  logic [COLOUR_W-1:0]     req_colour,
  output logic [ROM_ADDR_W-1:0]   rom_addr,
  input  logic [COLOUR_W-1:0]     rom_q,
  output logic [X_W-1:0]          x,
  output logic [Y_W-1:0]          y,
  output logic [COLOUR_W-1:0]     colour,
  output logic                    plot,
  output logic                    busy,
  output logic                    done
);

`ifdef SPRITE_TRANSPARENCY_EN
  localparam logic TRANSP_EN = 1'b1;
`else
  localparam logic TRANSP_EN = 1'b0;
`endif

  localparam logic [X_W:0] X_LIM = (X_W + 1)'(SCREEN_W);
  localparam logic [Y_W:0] Y_LIM = (Y_W + 1)'(SCREEN_H);

  blit_state_t             state;
  logic                    flush_cnt;
  logic                    mode_clear;
  logic [X_W-1:0]          lat_x;
  logic [Y_W-1:0]          lat_y;
  logic [SPRITE_IDX_W-1:0] lat_id;
  logic [COLOUR_W-1:0]     lat_colour;

  logic                    accept;
  logic [X_W-1:0]          inner_lim;
  logic [Y_W-1:0]          outer_lim;
  logic [X_W-1:0]          cnt_inner;
  logic [Y_W-1:0]          cnt_outer;
  logic                    cnt_last;

  logic [X_W:0]            scan_x;
  logic [Y_W:0]            scan_y;

  logic                    s1_valid;
  logic                    s1_inb;
  logic [X_W-1:0]          s1_x;
  logic [Y_W-1:0]          s1_y;
  logic                    key_hit;

  assign accept    = (state == ST_IDLE) && req_valid;
  assign inner_lim = mode_clear ? X_W'(SCREEN_W) : X_W'(SPRITE_DIM);
  assign outer_lim = mode_clear ? Y_W'(SCREEN_H) : Y_W'(SPRITE_DIM);

  raster_counter #(
    .IW (X_W),
    .OW (Y_W)
  ) u_raster (
    .clk       (clk),
    .reset     (reset),
    .clr       (accept),
    .en        (state == ST_SCAN),
    .inner_lim (inner_lim),
    .outer_lim (outer_lim),
    .inner     (cnt_inner),
    .outer     (cnt_outer),
    .last      (cnt_last)
  );

  assign rom_addr = rom_addr_of(lat_id, cnt_outer[ROM_COORD_W-1:0],
                                cnt_inner[ROM_COORD_W-1:0]);

  // Sprite coordinates are widened by one bit so off-screen overflow clips
  // instead of wrapping back onto the visible area.
  always_comb begin
    scan_x = '0;
    scan_y = '0;
    if (mode_clear) begin
      scan_x = {1'b0, cnt_inner};
      scan_y = {1'b0, cnt_outer};
    end else begin
      scan_x = {1'b0, lat_x} + (X_W + 1)'(cnt_inner[ROM_COORD_W-1:0]);
      scan_y = {1'b0, lat_y} + (Y_W + 1)'(cnt_outer[ROM_COORD_W-1:0]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      flush_cnt  <= 1'b0;
      mode_clear <= 1'b0;
      lat_x      <= '0;
      lat_y      <= '0;
      lat_id     <= '0;
      lat_colour <= '0;
      req_ready  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            mode_clear <= req_clear;
            lat_x      <= req_x;
            lat_y      <= req_y;
            lat_id     <= req_id;
            lat_colour <= req_colour;
            req_ready  <= 1'b0;
            busy       <= 1'b1;
            state      <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (cnt_last) begin
            flush_cnt <= 1'b0;
            state     <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (flush_cnt) begin
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            flush_cnt <= 1'b1;
          end
        end
        ST_DONE: begin
          done      <= 1'b0;
          busy      <= 1'b0;
          req_ready <= 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Stage 1 runs in parallel with the synchronous ROM read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_inb   <= 1'b0;
      s1_x     <= '0;
      s1_y     <= '0;
    end else begin
      s1_valid <= (state == ST_SCAN);
      if (state == ST_SCAN) begin
        s1_inb <= (scan_x < X_LIM) && (scan_y < Y_LIM);
        s1_x   <= scan_x[X_W-1:0];
        s1_y   <= scan_y[Y_W-1:0];
      end
    end
  end

  assign key_hit = TRANSP_EN && !mode_clear && (rom_q == TRANSPARENT_COLOUR);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      plot   <= 1'b0;
      x      <= '0;
      y      <= '0;
      colour <= '0;
    end else begin
      plot <= s1_valid && s1_inb && !key_hit;
      if (s1_valid) begin
        x      <= s1_x;
        y      <= s1_y;
        colour <= mode_clear ? lat_colour : rom_q;
      end
    end
  end

endmodule

// File: tb/tb_sprite_blitter.sv
// Self-checking bench for sprite_blitter: directed and randomized commands
// checked cycle by cycle against a pixel-list reference model.
module tb_sprite_blitter;

  localparam int SW = 320;
  localparam int SH = 240;

`ifdef SPRITE_TRANSPARENCY_EN
  localparam bit TRANSP = 1'b1;
`else
  localparam bit TRANSP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic       req_clear;
  logic [8:0] req_x;
  logic [7:0] req_y;
  logic [1:0] req_id;
  logic [2:0] req_colour;
  logic [9:0] rom_addr;
  logic [2:0] rom_q = 3'b000;
  logic [8:0] x;
  logic [7:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       done;

  logic [2:0] mem [0:1023];

  int n_assert = 0;
  int n_fail   = 0;

  sprite_blitter dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_clear  (req_clear),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_id     (req_id),
    .req_colour (req_colour),
    .rom_addr   (rom_addr),
    .rom_q      (rom_q),
    .x          (x),
    .y          (y),
    .colour     (colour),
    .plot       (plot),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_q <= mem[rom_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_x"},        32'(x),        0);
    chk({tag, "_y"},        32'(y),        0);
    chk({tag, "_colour"},   32'(colour),   0);
    chk({tag, "_plot"},     32'(plot),     0);
    chk({tag, "_done"},     32'(done),     0);
    chk({tag, "_busy"},     32'(busy),     0);
    chk({tag, "_rom_addr"}, 32'(rom_addr), 0);
    chk({tag, "_ready"},    32'(req_ready), 1);
  endtask

  // Reference: pixel k of a command, from screen/sprite geometry.
  function automatic void model_pix(input bit clr, input int ox, input int oy,
                                    input int id, input int col, input int k,
                                    output bit p, output int ex, output int ey,
                                    output int ec);
    if (clr) begin
      ex = k % SW;
      ey = k / SW;
      ec = col;
      p  = 1'b1;
    end else begin
      ex = ox + (k % 16);
      ey = oy + (k / 16);
      ec = int'(mem[id * 256 + k]);
      p  = (ex < SW) && (ey < SH);
      if (TRANSP && ec == 0) p = 1'b0;
    end
  endfunction

  task automatic fill_pattern();
    for (int a = 0; a < 1024; a++) mem[a] = 3'(a);
  endtask

  task automatic fill_random_nonzero();
    for (int a = 0; a < 1024; a++) mem[a] = 3'($urandom_range(1, 7));
  endtask

  task automatic fill_col0_key(input int id);
    for (int k = 0; k < 256; k++)
      mem[id * 256 + k] = ((k % 16) == 0) ? 3'b000 : 3'($urandom_range(1, 7));
  endtask

  // Issue one command at a negedge with the DUT idle and check every cycle
  // up to and including the return of req_ready.
  task automatic run_cmd(input bit clr, input int ox, input int oy, input int id,
                         input int col, input bit hold, output int np);
    int  n;
    bit  p;
    int  ex, ey, ec;
    bit  exp_plot;
    n  = clr ? SW * SH : 256;
    np = 0;
    chk("ready_pre", 32'(req_ready), 1);
    req_valid  = 1'b1;
    req_clear  = clr;
    req_x      = 9'(ox);
    req_y      = 8'(oy);
    req_id     = 2'(id);
    req_colour = 3'(col);
    @(negedge clk);
    chk("busy_t0",  32'(busy), 1);
    chk("ready_t0", 32'(req_ready), 0);
    chk("plot_t0",  32'(plot), 0);
    if (!clr) chk("rom_addr_t0", 32'(rom_addr), 32'(id * 256));
    if (!hold) req_valid = 1'b0;
    for (int t = 1; t <= n + 3; t++) begin
      if (hold) begin
        req_x      = 9'($urandom);
        req_y      = 8'($urandom);
        req_id     = 2'($urandom);
        req_clear  = 1'($urandom);
        req_colour = 3'($urandom);
      end
      @(negedge clk);
      exp_plot = 1'b0;
      if (t >= 2 && t <= n + 1) begin
        model_pix(clr, ox, oy, id, col, t - 2, p, ex, ey, ec);
        exp_plot = p;
      end
      chk("plot", 32'(plot), 32'(exp_plot));
      if (exp_plot) begin
        chk("x",      32'(x),      32'(ex));
        chk("y",      32'(y),      32'(ey));
        chk("colour", 32'(colour), 32'(ec));
      end
      if (plot) np++;
      if (!clr && t < n) chk("rom_addr", 32'(rom_addr), 32'(id * 256 + t));
      chk("done",  32'(done),      32'(t == n + 2));
      chk("ready", 32'(req_ready), 32'(t == n + 3));
      chk("busy",  32'(busy),      32'(t <= n + 2));
    end
  endtask

  initial begin
    int np;
    reset      = 1'b0;
    req_valid  = 1'b0;
    req_clear  = 1'b0;
    req_x      = '0;
    req_y      = '0;
    req_id     = '0;
    req_colour = '0;
    fill_pattern();
    repeat (3) @(negedge clk);
    chk_reset_values("rst");
    reset = 1'b1;
    @(negedge clk);

    // Draw id 1 at (10,20) with q = addr[2:0]
    run_cmd(1'b0, 10, 20, 1, 0, 1'b0, np);
    chk("draw1_count", 32'(np), TRANSP ? 32'd224 : 32'd256);

    // Bottom-right corner clipping
    fill_random_nonzero();
    run_cmd(1'b0, 312, 232, 0, 0, 1'b0, np);
    chk("corner_count", 32'(np), 32'd64);

    // Randomized sprite draws over the whole coordinate range
    for (int i = 0; i < 4; i++) begin
      fill_random_nonzero();
      run_cmd(1'b0, int'($urandom_range(0, 511)), int'($urandom_range(0, 255)),
              int'($urandom_range(0, 3)), 0, 1'b0, np);
    end

    // req_valid held with scrambled fields during a draw, then accepted on idle
    run_cmd(1'b0, 100, 50, 2, 0, 1'b1, np);
    chk("hold_count", 32'(np), 32'd256);
    run_cmd(1'b0, 5, 6, 3, 0, 1'b0, np);
    chk("b2b_count", 32'(np), 32'd256);

    // Reset during pixel 100 of a draw
    req_valid = 1'b1;
    req_clear = 1'b0;
    req_x     = 9'd30;
    req_y     = 8'd40;
    req_id    = 2'd1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (102) @(negedge clk);
    chk("mid_plot", 32'(plot), 1);
    reset = 1'b0;
    #1;
    chk_reset_values("abort");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_done", 32'(done), 0);
      chk("abort_busy", 32'(busy), 0);
    end
    reset = 1'b1;
    @(negedge clk);
    run_cmd(1'b0, 30, 40, 1, 0, 1'b0, np);
    chk("after_abort_count", 32'(np), 32'd256);

    // Screen fill with colour 5
    run_cmd(1'b1, 0, 0, 0, 5, 1'b0, np);
    chk("clear_count", 32'(np), 32'd76800);
    chk("clear_last_x", 32'(x), 32'd319);
    chk("clear_last_y", 32'(y), 32'd239);

    // Column 0 keyed to the transparent colour
    fill_col0_key(2);
    run_cmd(1'b0, 40, 40, 2, 0, 1'b0, np);
    chk("key_count", 32'(np), TRANSP ? 32'd240 : 32'd256);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sprite_blitter.md
# sprite_blitter

Pixel-stream engine between the game control FSM and `vga_adapter`. It accepts one command at a time: either draw a 16x16 sprite from the graphics ROM at an (x, y) origin, or fill the whole screen with one colour. It emits one (x, y, colour, plot) tuple per clock with screen-edge clipping. It owns the ROM address bus and pulses `done` when a command finishes.

## Interface
Parameters:
- `SCREEN_W`, 320: visible width in pixels.
- `SCREEN_H`, 240: visible height in pixels.
- `TRANSPARENT_COLOUR`, 3'b000: colour key; used only when `SPRITE_TRANSPARENCY_EN` is defined.

Ports:
- `clk`  in  1  system clock (CLOCK_50 domain); single clock.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  command present.
- `req_ready`  out  1  block idle, command accepted on `req_valid && req_ready`.
- `req_clear`  in  1  1 = screen fill, 0 = sprite draw.
- `req_x`  in  9  sprite origin x, unsigned.
- `req_y`  in  8  sprite origin y, unsigned.
- `req_id`  in  2  sprite index, 0..3.
- `req_colour`  in  3  fill colour (clear only).
- `rom_addr`  out  10  `{id, row[3:0], col[3:0]}` to synchronous ROM.
- `rom_q`  in  3  ROM data, valid one cycle after the address is sampled.
- `x`  out  9  pixel x to `vga_adapter`.
- `y`  out  8  pixel y to `vga_adapter`.
- `colour`  out  3  pixel colour.
- `plot`  out  1  write enable for the current tuple.
- `busy`  out  1  high from acceptance to the end of `done`.
- `done`  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, SCAN, FLUSH, DONE.
- IDLE: `req_ready`=1. On accept, latch all `req_*` fields, clear the scan counters, and go to SCAN.
- SCAN, draw mode: counters col (inner) and row (outer) run 0..15; `rom_addr` = `{id,row,col}`, combinational from the counters.
- SCAN, clear mode: counters run x 0..SCREEN_W-1 (inner) and y 0..SCREEN_H-1 (outer), raster order.
- The last scan position moves the FSM to FLUSH. FLUSH lasts 2 cycles to drain the pipeline, then the FSM goes to DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- Pipeline: a 2-stage register chain carries coordinates and the valid bit alongside the ROM read.
- Draw coordinates: x = `req_x` + col, computed at 10 bits; y = `req_y` + row, computed at 9 bits.
- Clipping: a pixel with x ≥ SCREEN_W or y ≥ SCREEN_H outputs `plot`=0. Its coordinate outputs are truncated and don't-care.
- Clear mode outputs `colour` = latched `req_colour` and `plot`=1 for every pixel.
- Outside valid pixel cycles, `plot`=0 and `x`/`y`/`colour` hold their last values.
- `req_valid` while not IDLE is ignored. No queueing; the command fields may change freely.
- Reset values: `x`=0, `y`=0, `colour`=0, `plot`=0, `done`=0, `busy`=0, `rom_addr`=0, `req_ready`=1, state IDLE.
- Reset asserted mid-command aborts immediately with no `done` pulse.

## Timing
- Let accept occur at edge E0. Pixel k (0-based) appears on the outputs in the cycle after edge E(k+2).
- For N pixels: last pixel after E(N+1), `done` after E(N+2), `req_ready` high after E(N+3).
- Sprite draw: N=256, so the command occupies 259 cycles accept-to-ready.
- Clear: N=SCREEN_W·SCREEN_H = 76800 with default parameters.
- Back-to-back commands: the next accept is possible on the first IDLE edge. Minimum gap between commands is one `req_ready` cycle.

## Configuration
- `SPRITE_TRANSPARENCY_EN` defined: in draw mode, a pixel with `rom_q == TRANSPARENT_COLOUR` outputs `plot`=0, so the background is preserved. Clear mode is unaffected.
- Not defined: every in-bounds sprite pixel is plotted. `TRANSPARENT_COLOUR` is unused.
- Pipeline latency is identical in both builds.

## Structure
- Shared package `gfx_pkg` holds:
  - SCREEN_W/SCREEN_H defaults;
  - SPRITE_DIM=16 and SPRITE_IDX_W=2;
  - coordinate widths (9/8) and the colour width (3);
  - the FSM state enum;
  - the ROM address layout constants.
- One sub-module, `raster_counter`: a 2-D wrap counter with runtime inner/outer limits and a `last` flag. It is instanced once and loaded with 16/16 (draw) or SCREEN_W/SCREEN_H (clear).

## Test plan
- Draw id=1 at (10,20), ROM model q=addr[2:0]:
  - 256 plot cycles;
  - first tuple (10,20) after E2;
  - last tuple (25,35) after E257;
  - `done` after E258, `req_ready` after E259.
- Draw id=0 at (312,232): exactly 64 `plot`=1 cycles covering x 312..319 and y 232..239. `done` timing is unchanged (after E258).
- Clear with colour 3'b101:
  - 76800 `plot`=1 cycles, x wraps 319→0 as y increments;
  - final tuple (319,239);
  - `done` on the next cycle.
- Second `req_valid` held high during a draw: ignored, `req_ready`=0 throughout. It is accepted on the first IDLE edge after `done`.
- Reset pulled low at pixel 100 of a draw:
  - all outputs go to reset values immediately, `req_ready`=1, no `done` pulse;
  - a new draw after release completes with 256 pixels.
- Build with `SPRITE_TRANSPARENCY_EN` and a ROM whose col 0 is 3'b000: 240 plot cycles. Without the macro, the same stimulus gives 256.
